coeff_loader: RTL and testbench

Writer-side counterpart of the twiddle coefficient sequencer. It accepts a stream of packed complex coefficients over a valid/ready handshake and fills the shadow bank of a double-buffered register file. On a correctly framed set of exactly N words it swaps banks atomically. Downstream butterfly stages read the active bank by index, so a new coefficient set can be loaded while the current one stays in use.

---
 rtl/fft_coeff_pkg.sv | 40 ++++
 rtl/coeff_loader_if.sv | 24 ++
 rtl/coeff_bank2.sv | 50 +++++
 rtl/coeff_loader.sv | 126 ++++++++++++
 tb/tb_coeff_loader.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_coeff_pkg.sv
// Shared types and helpers for the twiddle coefficient loader/sequencer pair.
// Complex words are packed {re, im}, re in the upper half.
package fft_coeff_pkg;

    localparam int COEFF_NBITS = 11;
    localparam int COEFF_N     = 32;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_SWAP  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [COEFF_NBITS-1:0] re;
        logic [COEFF_NBITS-1:0] im;
    } cplx_t;

    function automatic cplx_t cplx_pack(input logic [COEFF_NBITS-1:0] re,
                                        input logic [COEFF_NBITS-1:0] im);
        cplx_t c;
        c.re = re;
        c.im = im;
        return c;
    endfunction

    function automatic logic [COEFF_NBITS-1:0] cplx_re(input cplx_t c);
        return c.re;
    endfunction

    function automatic logic [COEFF_NBITS-1:0] cplx_im(input cplx_t c);
        return c.im;
    endfunction

    // Address width for an N-entry bank; never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/coeff_loader_if.sv
// Coefficient write stream: valid/ready handshake carrying {re, im} words and a set delimiter.
// The source drives valid/data/last; the loader drives ready.
interface coeff_loader_if #(
    parameter int NBITS = 11
);
    logic                 in_valid;
    logic [2*NBITS-1:0]   in_data;
    logic                 in_last;
    logic                 in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/coeff_bank2.sv
// Double-buffered N-entry coefficient store: writes land in the shadow bank, reads see the active bank.
// Read is registered (1 cycle), no enable; no backpressure.
module coeff_bank2 #(
    parameter int NBITS  = 11,
    parameter int N      = 32,
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sel,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [2*NBITS-1:0]   wr_data,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [2*NBITS-1:0]   rd_data
);

    logic [2*NBITS-1:0] bank0_q [N];
    logic [2*NBITS-1:0] bank1_q [N];
    logic [2*NBITS-1:0] rd_data_q;

    // sel=0: bank0 active, bank1 shadow; sel=1: the reverse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                bank0_q[i] <= '0;
                bank1_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            if (wr_en) begin
                if (sel) begin
                    bank0_q[wr_addr] <= wr_data;
                end else begin
                    bank1_q[wr_addr] <= wr_data;
                end
            end
            if (int'(rd_addr) >= N) begin
                rd_data_q <= '0;
            end else if (sel) begin
                rd_data_q <= bank1_q[rd_addr];
            end else begin
                rd_data_q <= bank0_q[rd_addr];
            end
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/coeff_loader.sv
// Fills the shadow coefficient bank from a framed stream and swaps banks on a set of exactly N words.
// Read latency 1 cycle; in_ready drops for the single SWAP cycle and while in reset.
module coeff_loader
    import fft_coeff_pkg::*;
#(
    parameter  int NBITS  = 11,
    parameter  int N      = 32,
    localparam int ADDR_W = addr_w(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    coeff_loader_if.slave        in_if,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [2*NBITS-1:0]   rd_data,
    output logic                 bank_valid,
    output logic                 swap_pulse,
    output logic                 err_short,
    output logic                 err_long,
    input  logic                 clr_err
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic                sel_q, sel_d;
    logic                bank_valid_q, bank_valid_d;
    logic                err_short_q, err_short_d;
    logic                err_long_q, err_long_d;
    logic                run_q;
    logic                xfer;
    logic                at_last;
    logic                wr_en;

    // run_q keeps ready low until the first edge after reset release.
    assign in_if.in_ready = run_q && (state_q != ST_SWAP);
    assign xfer           = in_if.in_valid && in_if.in_ready;
    assign at_last        = (wr_cnt_q == ADDR_W'(N - 1));

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        sel_d        = sel_q;
        bank_valid_d = bank_valid_q;
        err_short_d  = clr_err ? 1'b0 : err_short_q;
        err_long_d   = clr_err ? 1'b0 : err_long_q;
        wr_en        = 1'b0;
        swap_pulse   = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (xfer) begin
                    wr_en = 1'b1;
                    if (!at_last) begin
                        if (in_if.in_last) begin
                            err_short_d = 1'b1;
                            wr_cnt_d    = '0;
                        end else begin
                            wr_cnt_d = wr_cnt_q + ADDR_W'(1);
                        end
                    end else if (in_if.in_last) begin
                        state_d = ST_SWAP;
                    end else begin
                        err_long_d = 1'b1;
                        wr_cnt_d   = '0;
                        state_d    = ST_DRAIN;
                    end
                end
            end
            ST_SWAP: begin
                swap_pulse   = 1'b1;
                sel_d        = ~sel_q;
                bank_valid_d = 1'b1;
                wr_cnt_d     = '0;
                state_d      = ST_FILL;
            end
            ST_DRAIN: begin
                // Overlong set: swallow words until its delimiter, write nothing.
                if (xfer && in_if.in_last) begin
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_FILL;
            wr_cnt_q     <= '0;
            sel_q        <= 1'b0;
            bank_valid_q <= 1'b0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            sel_q        <= sel_d;
            bank_valid_q <= bank_valid_d;
            err_short_q  <= err_short_d;
            err_long_q   <= err_long_d;
            run_q        <= 1'b1;
        end
    end

    assign bank_valid = bank_valid_q;
    assign err_short  = err_short_q;
    assign err_long   = err_long_q;

    coeff_bank2 #(
        .NBITS  (NBITS),
        .N      (N),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .sel     (sel_q),
        .wr_en   (wr_en),
        .wr_addr (wr_cnt_q),
        .wr_data (in_if.in_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_coeff_loader.sv
// Self-checking bench for coeff_loader: framed sets, bursts, short/long errors, swap timing, mid-set reset.
module tb_coeff_loader;
    import fft_coeff_pkg::*;

    localparam int NB = 11;
    localparam int N  = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr_err = 1'b0;
    logic [4:0]  rd_addr = '0;
    logic [21:0] rd_data;
    logic        bank_valid;
    logic        swap_pulse;
    logic        err_short;
    logic        err_long;

    coeff_loader_if #(.NBITS(NB)) bus ();

    coeff_loader #(.NBITS(NB), .N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_if      (bus),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .bank_valid (bank_valid),
        .swap_pulse (swap_pulse),
        .err_short  (err_short),
        .err_long   (err_long),
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;
    int swaps_seen = 0;
    int          exp_swap_q[$];
    logic [21:0] rd_exp_q[$];

    typedef struct {
        logic [4:0]  addr;
        logic [21:0] exp;
    } rd_vec_t;

    rd_vec_t ramp_tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Swap scoreboard: each committing transfer queues the cycle its pulse must show up in.
    always @(negedge clk) begin
        int e;
        if (rst && swap_pulse) begin
            swaps_seen++;
            if (exp_swap_q.size() == 0) begin
                check("unexpected_swap", {31'd0, swap_pulse}, 32'd0);
            end else begin
                e = exp_swap_q.pop_front();
                check("swap_cycle", cyc, e);
                check("swap_in_ready", {31'd0, bus.in_ready}, 32'd0);
            end
        end
    end

    function automatic logic [21:0] word(input int kind, input int i);
        cplx_t c;
        case (kind)
            0: c = cplx_pack(11'(i), 11'(-i));
            1: c = cplx_pack(11'(i + 100), 11'(i));
            2: c = cplx_pack(11'h3AA, 11'(i));
            3: c = cplx_pack(11'(i), 11'(i + 7));
            4: c = cplx_pack(11'h7FF, 11'(i));
            5: c = cplx_pack(11'(i * 3), ~11'(i));
            6: c = (i == 0) ? 22'h1 : cplx_pack(11'(i), 11'h001);
            7: c = (i == 0) ? 22'h2 : cplx_pack(11'(i), 11'h002);
            8: c = cplx_pack(11'h155, 11'(i));
            default: c = cplx_pack(11'(i + 200), 11'(11'h400 + i));
        endcase
        return c;
    endfunction

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until it is accepted; returns at posedge+1 of the transfer edge.
    task automatic send(input logic [21:0] d, input logic last, input bit commit);
        int  guard;
        bit  done;
        guard = 0;
        done  = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                if (commit) exp_swap_q.push_back(cyc + 1);
                done = 1'b1;
            end else begin
                guard++;
                if (guard > 20) begin
                    check("ready_timeout", {31'd0, bus.in_ready}, 32'd1);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_set(input int kind, input int nwords, input int last_at,
                            input bit commit, input int maxgap);
        int gap;
        for (int i = 0; i < nwords; i++) begin
            gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
            if (gap > 0) idle(gap);
            send(word(kind, i), i == last_at, commit && (i == last_at));
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [4:0] a, input logic [21:0] e);
        rd_addr = a;
        rd_exp_q.push_back(e);
        @(posedge clk);
        #1;
        check(name, {10'd0, rd_data}, {10'd0, rd_exp_q.pop_front()});
    endtask

    task automatic run_reads(input string name, input int kind);
        int addrs[4] = '{0, 5, 17, 31};
        for (int j = 0; j < 4; j++) begin
            read_check(name, 5'(addrs[j]), word(kind, addrs[j]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        ramp_tbl[0] = '{5'd5,  {11'h005, 11'h7FB}};
        ramp_tbl[1] = '{5'd0,  {11'h000, 11'h000}};
        ramp_tbl[2] = '{5'd1,  {11'h001, 11'h7FF}};
        ramp_tbl[3] = '{5'd31, {11'h01F, 11'h7E1}};
        ramp_tbl[4] = '{5'd16, {11'h010, 11'h7F0}};

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",   {31'd0, bus.in_ready}, 32'd0);
        check("rst_bank_valid", {31'd0, bank_valid},   32'd0);
        check("rst_swap_pulse", {31'd0, swap_pulse},   32'd0);
        check("rst_err_short",  {31'd0, err_short},    32'd0);
        check("rst_err_long",   {31'd0, err_long},     32'd0);
        check("rst_rd_data",    {10'd0, rd_data},      32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", {31'd0, bus.in_ready}, 32'd1);
        read_check("empty_read", 5'd3, 22'h0);

        // Ramp set, continuous valid
        send_set(0, N, N - 1, 1'b1, 0);
        idle(2);
        check("ramp_bank_valid", {31'd0, bank_valid}, 32'd1);
        for (int j = 0; j < 5; j++) begin
            read_check("ramp_read", ramp_tbl[j].addr, ramp_tbl[j].exp);
        end

        // Bursty set with random gaps
        send_set(1, N, N - 1, 1'b1, 3);
        idle(2);
        run_reads("burst_read", 1);

        // Short set: last on word 9, clear asserted in the same cycle as the error
        check("pre_short_err", {31'd0, err_short}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            if (i == 9) clr_err = 1'b1;
            send(word(2, i), i == 9, 1'b0);
            clr_err = 1'b0;
        end
        idle(2);
        check("short_err_short", {31'd0, err_short}, 32'd1);
        check("short_err_long",  {31'd0, err_long},  32'd0);
        run_reads("short_unchanged", 1);
        send_set(3, N, N - 1, 1'b1, 0);
        idle(2);
        run_reads("after_short_read", 3);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        check("short_cleared", {31'd0, err_short}, 32'd0);

        // Long set: 40 words, last on word 39
        for (int i = 0; i < 40; i++) begin
            send(word(4, i), i == 39, 1'b0);
            if (i == 30) check("long_before_31", {31'd0, err_long}, 32'd0);
            if (i == 31) check("long_after_31",  {31'd0, err_long}, 32'd1);
        end
        idle(2);
        check("long_no_short", {31'd0, err_short}, 32'd0);
        run_reads("long_unchanged", 3);
        send_set(5, N, N - 1, 1'b1, 0);
        idle(2);
        run_reads("after_long_read", 5);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        check("long_cleared", {31'd0, err_long}, 32'd0);

        // Held read address across a swap
        send_set(6, N, N - 1, 1'b1, 0);
        idle(2);
        rd_addr = 5'd0;
        for (int i = 0; i < N; i++) begin
            send(word(7, i), i == N - 1, i == N - 1);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("hold_edge_k",  {10'd0, rd_data}, 32'h1);
        @(posedge clk);
        #1;
        check("hold_edge_k1", {10'd0, rd_data}, 32'h1);
        @(posedge clk);
        #1;
        check("hold_edge_k2", {10'd0, rd_data}, 32'h2);
        idle(2);

        // Mid-set reset after an error and 16 words
        send_set(8, 3, 2, 1'b0, 0);
        send_set(8, 16, -1, 1'b0, 0);
        bus.in_valid = 1'b1;
        check("pre_rst_err_short", {31'd0, err_short}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_in_ready",   {31'd0, bus.in_ready}, 32'd0);
        check("mid_rst_bank_valid", {31'd0, bank_valid},   32'd0);
        check("mid_rst_err_short",  {31'd0, err_short},    32'd0);
        check("mid_rst_err_long",   {31'd0, err_long},     32'd0);
        check("mid_rst_swap",       {31'd0, swap_pulse},   32'd0);
        check("mid_rst_rd_data",    {10'd0, rd_data},      32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rerelease_ready", {31'd0, bus.in_ready}, 32'd1);
        send_set(9, N, N - 1, 1'b1, 2);
        idle(2);
        check("post_rst_bank_valid", {31'd0, bank_valid}, 32'd1);
        run_reads("post_rst_read", 9);

        idle(3);
        check("pending_swaps", exp_swap_q.size(), 32'd0);
        check("swap_count", swaps_seen, 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
